// File: rtl/tdm_demux_pkg.sv
// Shared types and helpers for the TDM receive demultiplexer.
// Build option: TDM_DEMUX_STRICT_SYNC_EN (fsync required on every slot 0).
package tdm_demux_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Slot index width; N below 2 still gets one bit.
   function automatic int slot_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Wrapping 0..N-1 slot counter with load-to-0 and load-to-1.
module tdm_slot_ctr
   import tdm_demux_pkg::*;
#(
   parameter int N  = 2,
   parameter int SW = slot_w(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          ld0,
   input  logic          ld1,
   output logic [SW-1:0] q
);

   localparam logic [SW-1:0] LAST = SW'(N - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (ld0) begin
         q <= '0;
      end else if (ld1) begin
         q <= SW'(1);
      end else if (en) begin
         q <= (q == LAST) ? '0 : q + SW'(1);
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: frame alignment, shadow capture, atomic output.
// Build option: TDM_DEMUX_STRICT_SYNC_EN (slot 0 without fsync drops lock).
module tdm_demux
   import tdm_demux_pkg::*;
#(
   parameter int W = 8,
   parameter int N = 2,
   localparam int SW = slot_w(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   din,
   input  logic           din_vld,
   input  logic           fsync,
   output logic [N*W-1:0] dout,
   output logic           dout_vld,
   output logic [SW-1:0]  slot,
   output logic           locked,
   output logic           err,
   input  logic           err_clr
);

   localparam logic [SW-1:0] LAST = SW'(N - 1);

   state_t       state;
   logic [W-1:0] shadow [N-1];
   logic         go;
   logic         early;
   logic         drop;
   logic         take;
   logic         last;

   assign go    = din_vld & fsync & (state == HUNT);
   assign early = din_vld & fsync & (state == RUN) & (slot != '0);
`ifdef TDM_DEMUX_STRICT_SYNC_EN
   assign drop  = din_vld & ~fsync & (state == RUN) & (slot == '0);
`else
   assign drop  = 1'b0;
`endif
   assign take  = din_vld & (state == RUN) & ~early & ~drop;
   assign last  = take & (slot == LAST);

   assign locked = (state == RUN);

   tdm_slot_ctr #(
      .N  (N),
      .SW (SW)
   ) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (take),
      .ld0   (drop),
      .ld1   (go | early),
      .q     (slot)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= HUNT;
         dout_vld <= 1'b0;
         err      <= 1'b0;
      end else begin
         dout_vld <= last;
         unique case (state)
            HUNT: if (go) state <= RUN;
            RUN:  if (drop) state <= HUNT;
         endcase
         if (early | drop) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end
      end
   end

   // Final slot bypasses its shadow straight into dout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N - 1; k++) begin
            shadow[k] <= '0;
         end
         dout <= '0;
      end else begin
         for (int k = 0; k < N - 1; k++) begin
            if (((go | early) && (k == 0)) ||
                (take && (slot == SW'(k)))) begin
               shadow[k] <= din;
            end
         end
         if (last) begin
            for (int k = 0; k < N - 1; k++) begin
               dout[k*W +: W] <= shadow[k];
            end
            dout[(N-1)*W +: W] <= din;
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux with N=2 and N=4 instances.
module tb_tdm_demux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [7:0]  x2 = '0;
   logic        v2 = 1'b0;
   logic        f2 = 1'b0;
   logic        c2 = 1'b0;
   logic [15:0] dout2;
   logic        dv2;
   logic [0:0]  sl2;
   logic        lk2;
   logic        er2;

   logic [7:0]  x4 = '0;
   logic        v4 = 1'b0;
   logic        f4 = 1'b0;
   logic        c4 = 1'b0;
   logic [31:0] dout4;
   logic        dv4;
   logic [1:0]  sl4;
   logic        lk4;
   logic        er4;

   int nerr = 0;
   int nchk = 0;

   always #5 clk = ~clk;

   tdm_demux #(.W(8), .N(2)) u2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (x2),
      .din_vld  (v2),
      .fsync    (f2),
      .dout     (dout2),
      .dout_vld (dv2),
      .slot     (sl2),
      .locked   (lk2),
      .err      (er2),
      .err_clr  (c2)
   );

   tdm_demux #(.W(8), .N(4)) u4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (x4),
      .din_vld  (v4),
      .fsync    (f4),
      .dout     (dout4),
      .dout_vld (dv4),
      .slot     (sl4),
      .locked   (lk4),
      .err      (er4),
      .err_clr  (c4)
   );

   // Reference model: frame position, shadow words, outputs.
   int          nch [2] = '{2, 4};
   bit          mlk [2];
   int          mpos [2];
   logic [7:0]  msh [2][4];
   logic [31:0] mdout [2];
   bit          mvld [2];
   bit          merr [2];

   task automatic mclear();
      for (int d = 0; d < 2; d++) begin
         mlk[d] = 0;
         mpos[d] = 0;
         mdout[d] = '0;
         mvld[d] = 0;
         merr[d] = 0;
         for (int k = 0; k < 4; k++) msh[d][k] = '0;
      end
   endtask

   task automatic mstep(input int d, input bit v, input bit f,
                        input logic [7:0] x, input bit c);
      bit se;
      se = 0;
      mvld[d] = 0;
      if (v) begin
         if (!mlk[d]) begin
            if (f) begin
               msh[d][0] = x;
               mpos[d] = 1;
               mlk[d] = 1;
            end
         end else if (f && mpos[d] != 0) begin
            se = 1;
            msh[d][0] = x;
            mpos[d] = 1;
         end
`ifdef TDM_DEMUX_STRICT_SYNC_EN
         else if (!f && mpos[d] == 0) begin
            se = 1;
            mlk[d] = 0;
         end
`endif
         else begin
            msh[d][mpos[d]] = x;
            if (mpos[d] == nch[d] - 1) begin
               mdout[d] = '0;
               for (int k = 0; k < nch[d]; k++)
                  mdout[d] = mdout[d] | (32'(msh[d][k]) << (8 * k));
               mvld[d] = 1;
               mpos[d] = 0;
            end else begin
               mpos[d] = mpos[d] + 1;
            end
         end
      end
      if (se) merr[d] = 1;
      else if (c) merr[d] = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_model(input int d);
      if (d == 0) begin
         chk("m2_dout", 32'(dout2), mdout[0]);
         chk("m2_vld", 32'(dv2), 32'(mvld[0]));
         chk("m2_slot", 32'(sl2), 32'(mpos[0]));
         chk("m2_lock", 32'(lk2), 32'(mlk[0]));
         chk("m2_err", 32'(er2), 32'(merr[0]));
      end else begin
         chk("m4_dout", dout4, mdout[1]);
         chk("m4_vld", 32'(dv4), 32'(mvld[1]));
         chk("m4_slot", 32'(sl4), 32'(mpos[1]));
         chk("m4_lock", 32'(lk4), 32'(mlk[1]));
         chk("m4_err", 32'(er4), 32'(merr[1]));
      end
   endtask

   // One clock with target DUT d driven, the other idle.
   task automatic step(input int d, input bit v, input bit f,
                       input logic [7:0] x, input bit c);
      v2 = (d == 0) ? v : 1'b0;
      f2 = (d == 0) ? f : 1'b0;
      x2 = (d == 0) ? x : 8'h00;
      c2 = (d == 0) ? c : 1'b0;
      v4 = (d == 1) ? v : 1'b0;
      f4 = (d == 1) ? f : 1'b0;
      x4 = (d == 1) ? x : 8'h00;
      c4 = (d == 1) ? c : 1'b0;
      mstep(0, v2, f2, x2, c2);
      mstep(1, v4, f4, x4, c4);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      v2 = 0; f2 = 0; c2 = 0; x2 = '0;
      v4 = 0; f4 = 0; c4 = 0; x4 = '0;
      rst_n = 1'b0;
      mclear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit         rst;
      bit         v;
      bit         f;
      logic [7:0] x;
      bit         c;
      logic [15:0] dout;
      bit         vld;
      bit         lk;
      bit         e;
      bit         sl;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int cnt;
      tbl[0] = '{1, 1, 1, 8'h11, 0, 16'h0000, 0, 1, 0, 1};
      tbl[1] = '{0, 1, 0, 8'h22, 0, 16'h2211, 1, 1, 0, 0};
      tbl[2] = '{0, 0, 0, 8'h00, 0, 16'h2211, 0, 1, 0, 0};
      tbl[3] = '{1, 1, 0, 8'hAA, 0, 16'h0000, 0, 0, 0, 0};
      tbl[4] = '{0, 1, 0, 8'hBB, 0, 16'h0000, 0, 0, 0, 0};
      tbl[5] = '{0, 1, 1, 8'h01, 0, 16'h0000, 0, 1, 0, 1};
      tbl[6] = '{0, 1, 0, 8'h02, 0, 16'h0201, 1, 1, 0, 0};
`ifdef TDM_DEMUX_STRICT_SYNC_EN
      tbl[7] = '{0, 1, 0, 8'h33, 0, 16'h0201, 0, 0, 1, 0};
      tbl[8] = '{0, 1, 0, 8'h44, 0, 16'h0201, 0, 0, 1, 0};
`else
      tbl[7] = '{0, 1, 0, 8'h33, 0, 16'h0201, 0, 1, 0, 1};
      tbl[8] = '{0, 1, 0, 8'h44, 0, 16'h4433, 1, 1, 0, 0};
`endif
      tbl[9] = '{0, 0, 0, 8'h00, 1, tbl[8].dout, 0, tbl[8].lk, 0, 0};

      mclear();
      #2;
      chk("rst_dout2", 32'(dout2), 0);
      chk("rst_dout4", dout4, 0);
      chk("rst_lock4", 32'(lk4), 0);
      chk("rst_vld4", 32'(dv4), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         if (tbl[i].rst) do_reset();
         step(0, tbl[i].v, tbl[i].f, tbl[i].x, tbl[i].c);
         chk($sformatf("t%0d_dout", i), 32'(dout2), 32'(tbl[i].dout));
         chk($sformatf("t%0d_vld", i), 32'(dv2), 32'(tbl[i].vld));
         chk($sformatf("t%0d_lock", i), 32'(lk2), 32'(tbl[i].lk));
         chk($sformatf("t%0d_err", i), 32'(er2), 32'(tbl[i].e));
         chk($sformatf("t%0d_slot", i), 32'(sl2), 32'(tbl[i].sl));
      end

      // N=4 frame with three idle cycles between words.
      do_reset();
      cnt = 0;
      for (int w = 1; w <= 4; w++) begin
         step(1, 1, w == 1, 8'(w), 0);
         check_model(1);
         cnt += int'(dv4);
         for (int g = 0; g < 3; g++) begin
            step(1, 0, 0, 8'hFF, 0);
            check_model(1);
            cnt += int'(dv4);
            if (w < 4) chk("gap_slot", 32'(sl4), 32'(w));
         end
      end
      chk("gap_strobes", 32'(cnt), 1);
      chk("gap_dout", dout4, 32'h04030201);

      // Early resync mid-frame.
      step(1, 1, 1, 8'hA0, 0);
      step(1, 1, 0, 8'hB0, 0);
      step(1, 1, 0, 8'hC0, 0);
      step(1, 1, 0, 8'hD0, 0);
      chk("lk_dout", dout4, 32'hD0C0B0A0);
      step(1, 1, 0, 8'h10, 0);
      step(1, 1, 0, 8'h20, 0);
      step(1, 1, 1, 8'h55, 0);
      chk("early_err", 32'(er4), 1);
      chk("early_vld", 32'(dv4), 0);
      chk("early_slot", 32'(sl4), 1);
      step(1, 1, 0, 8'h66, 0);
      step(1, 1, 0, 8'h77, 0);
      chk("early_hold", dout4, 32'hD0C0B0A0);
      step(1, 1, 0, 8'h88, 0);
      chk("early_dout", dout4, 32'h88776655);
      chk("early_vld2", 32'(dv4), 1);
      step(1, 0, 0, 8'h00, 1);
      chk("clr_err", 32'(er4), 0);

      // Slot 0 without fsync while locked.
      step(1, 1, 0, 8'h01, 0);
`ifdef TDM_DEMUX_STRICT_SYNC_EN
      chk("s0_err", 32'(er4), 1);
      chk("s0_lock", 32'(lk4), 0);
`else
      chk("s0_err", 32'(er4), 0);
      chk("s0_lock", 32'(lk4), 1);
`endif
      step(1, 1, 0, 8'h02, 0);
      step(1, 1, 0, 8'h03, 0);
      step(1, 1, 0, 8'h04, 0);
      check_model(1);
`ifndef TDM_DEMUX_STRICT_SYNC_EN
      chk("s0_dout", dout4, 32'h04030201);
`endif

      // Async reset in the middle of an N=2 frame.
      step(0, 1, 1, 8'h5A, 0);
      step(0, 1, 0, 8'hA5, 0);
      chk("pre_rst", 32'(dout2), 32'h0000A55A);
      step(0, 1, 1, 8'h11, 0);
      rst_n = 1'b0;
      mclear();
      #1;
      chk("mid_rst_dout", 32'(dout2), 0);
      chk("mid_rst_vld", 32'(dv2), 0);
      chk("mid_rst_lock", 32'(lk2), 0);
      chk("mid_rst_slot", 32'(sl2), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(0, 1, 0, 8'h22, 0);
      chk("post_rst_lock", 32'(lk2), 0);
      chk("post_rst_vld", 32'(dv2), 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         int d;
         d = i % 2;
         step(d, $urandom_range(3, 0) != 0, $urandom_range(9, 0) == 0,
              8'($urandom), $urandom_range(19, 0) == 0);
         check_model(0);
         check_model(1);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
